// File: rtl/uart_pkg.sv
// Shared UART definitions: baud rate codes and the transmit scheduler state encoding.
package uart_pkg;

  localparam logic [1:0] BR2400     = 2'b00;
  localparam logic [1:0] BR4800     = 2'b01;
  localparam logic [1:0] BR9600     = 2'b10;
  localparam logic [1:0] BR19200    = 2'b11;
  localparam logic [1:0] BR_DEFAULT = BR9600;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_RECFG = 3'd2,
    ST_START = 3'd3,
    ST_WAIT  = 3'd4
  } tx_sched_state_t;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Client-side and transmitter-side signals of the TX scheduler, bundled as one interface.
// Handshakes: req[i] is a valid level held until the one-cycle gnt[i]; tx_start launches a
// frame and tx_data holds until the tx_done pulse; a frame may start only while tx_busy=0.
interface uart_tx_sched_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  localparam int OW = $clog2(NREQ);

  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ*2-1:0]  req_rate;
  logic [NREQ-1:0]    gnt;
  logic [1:0]         baud_rate;
  logic               baud_rstn;
  logic               tx_start;
  logic [DW-1:0]      tx_data;
  logic               tx_busy;
  logic               tx_done;
  logic               busy;
  logic [OW-1:0]      owner;

  modport master (
    input  req, req_data, req_rate, tx_busy, tx_done,
    output gnt, baud_rate, baud_rstn, tx_start, tx_data, busy, owner
  );

  modport slave (
    output req, req_data, req_rate, tx_busy, tx_done,
    input  gnt, baud_rate, baud_rstn, tx_start, tx_data, busy, owner
  );

endinterface

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above the pointer, wrapping around.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IW-1:0]   o_idx
);

  logic          w_found;
  logic [IW-1:0] w_j;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = IW'((int'(i_ptr) + k) % NREQ);
      if (!w_found && i_req[w_j]) begin
        w_found    = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter and baud generator among NREQ requesters, round-robin,
// retuning the baud rate only between frames behind a GUARD-cycle generator reset.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DW    = 8,
  parameter int GUARD = 4
) (
  input  logic             clk,
  input  logic             rstn,
  uart_tx_sched_if.master  bus,
  output tx_sched_state_t  o_state
);

  localparam int IW = $clog2(NREQ);
  localparam int GW = $clog2(GUARD + 1);

  tx_sched_state_t r_state;
  logic [NREQ-1:0] r_gnt;
  logic [1:0]      r_baud_rate;
  logic [1:0]      r_pend_rate;
  logic            r_baud_rstn;
  logic            r_tx_start;
  logic [DW-1:0]   r_tx_data;
  logic            r_busy;
  logic [IW-1:0]   r_owner;
  logic [IW-1:0]   r_ptr;
  logic [GW-1:0]   r_guard;

  logic [NREQ-1:0] w_arb_gnt;
  logic [IW-1:0]   w_arb_idx;
  logic [DW-1:0]   w_sel_data;
  logic [1:0]      w_sel_rate;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_req (bus.req),
    .i_ptr (r_ptr),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx)
  );

  assign w_sel_data = bus.req_data[int'(w_arb_idx)*DW +: DW];
  assign w_sel_rate = bus.req_rate[int'(w_arb_idx)*2 +: 2];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_INIT;
      r_gnt       <= '0;
      r_baud_rate <= BR_DEFAULT;
      r_pend_rate <= BR_DEFAULT;
      r_baud_rstn <= 1'b0;
      r_tx_start  <= 1'b0;
      r_tx_data   <= '0;
      r_busy      <= 1'b1;
      r_owner     <= '0;
      r_ptr       <= '0;
      r_guard     <= '0;
    end else begin
      r_gnt      <= '0;
      r_tx_start <= 1'b0;
      case (r_state)
        ST_INIT: begin
          if (r_guard == GW'(GUARD - 1)) begin
            r_guard     <= '0;
            r_baud_rstn <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            r_guard <= r_guard + 1'b1;
          end
        end
        ST_IDLE: begin
          if (|bus.req) begin
            r_gnt       <= w_arb_gnt;
            r_tx_data   <= w_sel_data;
            r_pend_rate <= w_sel_rate;
            r_owner     <= w_arb_idx;
            r_ptr       <= (w_arb_idx == IW'(NREQ - 1)) ? '0 : w_arb_idx + 1'b1;
            r_busy      <= 1'b1;
            r_guard     <= '0;
            r_state     <= (w_sel_rate != r_baud_rate) ? ST_RECFG : ST_START;
          end
        end
        // The new rate lands together with the generator reset, so the rate
        // never moves while the generator is running.
        ST_RECFG: begin
          r_baud_rate <= r_pend_rate;
          r_baud_rstn <= 1'b0;
          if (r_guard == GW'(GUARD - 1)) begin
            r_guard <= '0;
            r_state <= ST_START;
          end else begin
            r_guard <= r_guard + 1'b1;
          end
        end
        ST_START: begin
          r_baud_rstn <= 1'b1;
          if (!bus.tx_busy) begin
            r_tx_start <= 1'b1;
            r_state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.tx_done) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.baud_rate = r_baud_rate;
  assign bus.baud_rstn = r_baud_rstn;
  assign bus.tx_start  = r_tx_start;
  assign bus.tx_data   = r_tx_data;
  assign bus.busy      = r_busy;
  assign bus.owner     = r_owner;
  assign o_state       = r_state;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: random clients and a transmitter model, checked against a
// transaction-level reference that predicts grants, frame starts and baud reset windows.
module tb_uart_tx_sched;
  import uart_pkg::*;

  localparam int NREQ  = 4;
  localparam int DW    = 8;
  localparam int GUARD = 4;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #10 clk = ~clk;

  uart_tx_sched_if #(.NREQ(NREQ), .DW(DW)) bus ();
  tx_sched_state_t dbg_state;

  uart_tx_sched #(.NREQ(NREQ), .DW(DW), .GUARD(GUARD)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .bus     (bus),
    .o_state (dbg_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- stimulus state ----------------
  logic [DW-1:0] cl_data [NREQ];
  logic [1:0]    cl_rate [NREQ];
  bit  arrive_en  = 0;
  int  arrive_pct = 0;
  int  rate_mode  = -1;
  bit  stray_en   = 0;
  bit  force_busy = 0;
  int  tx_fixed   = 0;
  int  tx_cnt     = 0;

  // ---------------- reference model ----------------
  int            cyc;
  int            m_ptr;
  logic [1:0]    m_rate;
  bit            m_idle, m_open, m_started;
  int            m_start_due, m_g_lo, m_g_hi;
  int            last_w;
  logic [1:0]    prev_baud;
  logic [DW-1:0] exp_q[$];
  int            gnt_log[$];

  function automatic int first_from(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    cyc       = 0;
    m_ptr     = 0;
    m_rate    = 2'b10;
    m_idle    = 0;
    m_open    = 0;
    m_started = 0;
    m_g_lo    = -10;
    m_g_hi    = -10;
    last_w    = -1;
    prev_baud = 2'b10;
    exp_q.delete();
    tx_cnt      = 0;
    bus.tx_busy = 1'b0;
    bus.tx_done = 1'b0;
  endtask

  task automatic pack_clients();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_data[i*DW +: DW] = cl_data[i];
      bus.req_rate[i*2 +: 2]   = cl_rate[i];
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_gnt"},       bus.gnt, 0);
    check({tag, "_tx_start"},  bus.tx_start, 0);
    check({tag, "_tx_data"},   bus.tx_data, 0);
    check({tag, "_baud_rate"}, bus.baud_rate, 2'b10);
    check({tag, "_baud_rstn"}, bus.baud_rstn, 0);
    check({tag, "_busy"},      bus.busy, 1);
    check({tag, "_owner"},     bus.owner, 0);
    check({tag, "_state"},     dbg_state, ST_INIT);
  endtask

  // One clock cycle: compare outputs with predictions, advance model, drive next inputs.
  task automatic step();
    logic [NREQ-1:0] req_prev;
    bit   busy_prev, done_prev, exp_g, exp_s, done_seen, rate_ch;
    int   w;
    @(negedge clk);
    cyc++;
    req_prev  = bus.req;
    busy_prev = bus.tx_busy;
    done_prev = bus.tx_done;
    exp_g     = m_idle && (req_prev != '0);
    w         = exp_g ? first_from(req_prev, m_ptr) : -1;
    exp_s     = m_open && !m_started && (cyc >= m_start_due) && !busy_prev;
    done_seen = m_open && m_started && done_prev;

    check("gnt", bus.gnt, exp_g ? (32'd1 << w) : 32'd0);
    check("tx_start", bus.tx_start, exp_s);

    if (exp_g) begin
      check("owner", bus.owner, w);
      check("rr_repeat", (last_w == w) && ((req_prev & ~(NREQ'(1) << w)) != '0), 0);
      exp_q.push_back(cl_data[w]);
      rate_ch     = (cl_rate[w] != m_rate);
      m_rate      = cl_rate[w];
      m_idle      = 0;
      m_open      = 1;
      m_started   = 0;
      m_start_due = cyc + (rate_ch ? GUARD + 1 : 1);
      if (rate_ch) begin
        m_g_lo = cyc + 1;
        m_g_hi = cyc + GUARD;
      end
      m_ptr  = (w + 1) % NREQ;
      last_w = w;
      gnt_log.push_back(w);
      bus.req[w] = 1'b0;
      cl_data[w] = DW'($urandom);
    end
    if (exp_s) begin
      m_started = 1;
      if (exp_q.size() == 0) check("tx_data_none", 1, 0);
      else check("tx_data", bus.tx_data, exp_q.pop_front());
      check("baud_rate_at_start", bus.baud_rate, m_rate);
    end
    if (done_seen) begin
      m_open    = 0;
      m_started = 0;
      m_idle    = 1;
    end
    if (cyc == GUARD) m_idle = 1;

    check("busy", bus.busy, !m_idle);
    check("baud_rstn", bus.baud_rstn, !((cyc < GUARD) || (cyc >= m_g_lo && cyc <= m_g_hi)));
    if (m_started) check("baud_rate_frozen", bus.baud_rate, m_rate);
    if (bus.baud_rate != prev_baud) check("rate_moved_while_running", bus.baud_rstn, 0);
    prev_baud = bus.baud_rate;

    // transmitter driver
    bus.tx_done = 1'b0;
    if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) begin
        bus.tx_done = 1'b1;
        bus.tx_busy = 1'b0;
      end
    end else if (stray_en) begin
      bus.tx_busy = ($urandom_range(0, 2) == 0);
      bus.tx_done = ($urandom_range(0, 9) == 0);
    end else begin
      bus.tx_busy = force_busy;
    end
    if (bus.tx_start) begin
      tx_cnt      = (tx_fixed != 0) ? tx_fixed : $urandom_range(2, 12);
      bus.tx_busy = 1'b1;
      bus.tx_done = 1'b0;
    end

    // client driver
    if (arrive_en) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req[i] && $urandom_range(0, 99) < arrive_pct) begin
          bus.req[i] = 1'b1;
          cl_data[i] = DW'($urandom);
          cl_rate[i] = (rate_mode < 0) ? 2'($urandom_range(0, 3)) : 2'(rate_mode);
        end else if (bus.req[i] && $urandom_range(0, 3) == 0) begin
          cl_data[i] = DW'($urandom);
        end
      end
    end
    pack_clients();
  endtask

  task automatic run_idle(input int budget);
    int k;
    k = 0;
    while ((m_open || bus.req != '0 || !m_idle) && k < budget) begin
      step();
      k++;
    end
    if (k >= budget) check("timeout_idle", 1, 0);
  endtask

  // ---------------- sequence ----------------
  initial begin
    int k;
    bus.req      = '0;
    bus.req_data = '0;
    bus.req_rate = '0;
    bus.tx_busy  = 1'b0;
    bus.tx_done  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      cl_data[i] = '0;
      cl_rate[i] = 2'b10;
    end
    pack_clients();

    // reset and INIT
    repeat (3) @(negedge clk);
    check_reset_values("por");
    model_reset();
    rstn = 1'b1;
    repeat (GUARD + 2) step();
    check("init_state_idle", dbg_state, ST_IDLE);

    // same rate: requester 1
    tx_fixed   = 5;
    cl_data[1] = 8'hA5;
    cl_rate[1] = 2'b10;
    bus.req[1] = 1'b1;
    pack_clients();
    run_idle(100);
    check("first_grant", gnt_log[0], 1);

    // rate change: requester 0 at 19200
    cl_data[0] = 8'h3C;
    cl_rate[0] = 2'b11;
    bus.req[0] = 1'b1;
    pack_clients();
    run_idle(100);
    check("rate_after_change", bus.baud_rate, 2'b11);

    // all requesters held high, fixed 10-cycle frames
    gnt_log.delete();
    arrive_en  = 1;
    arrive_pct = 100;
    rate_mode  = 3;
    tx_fixed   = 10;
    k = 0;
    while (gnt_log.size() < 5 && k < 300) begin
      step();
      k++;
    end
    if (k >= 300) check("timeout_rr", 1, 0);
    arrive_en = 0;
    for (int i = 0; i < 5 && i < gnt_log.size(); i++) check("rr_order", gnt_log[i], (1 + i) % NREQ);
    run_idle(300);

    // transmitter held busy in START, then a stray done while idle
    force_busy = 1;
    cl_data[2] = 8'h5A;
    cl_rate[2] = 2'b11;
    bus.req[2] = 1'b1;
    pack_clients();
    repeat (8) step();
    force_busy = 0;
    run_idle(100);
    bus.tx_done = 1'b1;
    step();
    step();
    check("stray_done_idle", dbg_state, ST_IDLE);

    // random traffic with stray busy/done
    tx_fixed   = 0;
    rate_mode  = -1;
    arrive_en  = 1;
    arrive_pct = 5;
    stray_en   = 1;
    repeat (400) step();
    stray_en  = 0;
    arrive_en = 0;
    run_idle(300);

    // reset in the middle of a frame
    arrive_en  = 1;
    arrive_pct = 50;
    k = 0;
    while (!(m_started && tx_cnt > 2) && k < 300) begin
      step();
      k++;
    end
    if (k >= 300) check("timeout_wait", 1, 0);
    #2 rstn = 1'b0;
    #1 check_reset_values("mid");
    @(negedge clk);
    check_reset_values("mid_hold");
    model_reset();
    rstn = 1'b1;

    // long random run
    arrive_pct = 20;
    stray_en   = 1;
    repeat (2000) step();
    stray_en  = 0;
    arrive_en = 0;
    run_idle(500);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
